// File: rtl/bus_ctrl_pkg.sv
// Shared types for the 8088-style bus cycle arbiter: bus state encoding,
// the latched request record and the fixed bus cycle length.
package bus_ctrl_pkg;

    localparam int BUS_ADDR_W    = 19;
    localparam int BUS_DATA_W    = 8;
    localparam int BUS_CYCLE_LEN = 4;

    // T-state encoding matches the clock index inside the bus cycle
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'(BUS_CYCLE_LEN)
    } bus_state_e;

    typedef struct packed {
        logic                  we;
        logic                  mio;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic is_arb_point(input bus_state_e s);
        return (s == ST_IDLE) || (s == ST_T4);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way request arbiter. ARB_ROUND_ROBIN_EN selects round-robin with a
// last-served pointer; otherwise requester 0 has fixed priority.
module rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       en,
    output logic [1:0] win
);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_r;

    // Remember who was served last; reset value 1 lets requester 0 win first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (en && (req0 || req1)) begin
            last_r <= win[1];
        end else begin
            last_r <= last_r;
        end
    end

    // Tie goes to the requester not served most recently
    always_comb begin
        win = 2'b00;
        if (!en) begin
            win = 2'b00;
        end else if (req0 && req1) begin
            win = last_r ? 2'b01 : 2'b10;
        end else if (req0) begin
            win = 2'b01;
        end else if (req1) begin
            win = 2'b10;
        end else begin
            win = 2'b00;
        end
    end
`else
    logic unused_s;
    assign unused_s = clk ^ rst_n;

    // Fixed priority: requester 0 always wins
    always_comb begin
        win = 2'b00;
        if (!en) begin
            win = 2'b00;
        end else if (req0) begin
            win = 2'b01;
        end else if (req1) begin
            win = 2'b10;
        end else begin
            win = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Two-requester master for the 8088-compatible peripheral bus: arbitrates in
// IDLE/T4 and runs each grant as a T1..T4 cycle. Build option: ARB_ROUND_ROBIN_EN.
module bus_cycle_arbiter
    import bus_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_W,
    parameter int DATA_WIDTH = BUS_DATA_W
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic                  MIO0,
    input  logic                  MIO1,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  ALE,
    output logic                  RD,
    output logic                  WR,
    output logic                  CS_MEM,
    output logic                  CS_IO,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    inout  wire  [DATA_WIDTH-1:0] DATA
);

    bus_state_e            state_r, state_next_s;
    bus_req_t              req_r, req_next_s;
    logic                  owner_r, owner_next_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_next_s;
    logic [1:0]            win_s;
    logic                  arb_en_s;

    logic ale_r, rd_n_r, wr_n_r, cs_mem_r, cs_io_r;
    logic gnt0_r, gnt1_r, done0_r, done1_r, data_oe_r;
    logic ale_s, rd_n_s, wr_n_s, cs_mem_s, cs_io_s;
    logic gnt0_s, gnt1_s, done0_s, done1_s, data_oe_s;

    assign arb_en_s = is_arb_point(state_r);

    rr_arbiter u_arb (
        .clk   (CLK),
        .rst_n (RESET),
        .req0  (REQ0),
        .req1  (REQ1),
        .en    (arb_en_s),
        .win   (win_s)
    );

    // Next state, request latch and next-cycle output values
    always_comb begin
        state_next_s = state_r;
        req_next_s   = req_r;
        owner_next_s = owner_r;
        rdata_next_s = rdata_r;
        ale_s        = 1'b0;
        rd_n_s       = 1'b1;
        wr_n_s       = 1'b1;
        cs_mem_s     = 1'b0;
        cs_io_s      = 1'b0;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        done0_s      = 1'b0;
        done1_s      = 1'b0;
        data_oe_s    = 1'b0;

        case (state_r)
            ST_IDLE, ST_T4: begin
                if (win_s != 2'b00) begin
                    state_next_s = ST_T1;
                    owner_next_s = win_s[1];
                    if (win_s[1]) begin
                        req_next_s = '{we: WE1, mio: MIO1, addr: ADDR1, wdata: WDATA1};
                    end else begin
                        req_next_s = '{we: WE0, mio: MIO0, addr: ADDR0, wdata: WDATA0};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_T1: state_next_s = ST_T2;
            ST_T2: state_next_s = ST_T3;
            ST_T3: begin
                state_next_s = ST_T4;
                if (!req_r.we) begin
                    rdata_next_s = DATA;
                end else begin
                    rdata_next_s = rdata_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        case (state_next_s)
            ST_T1: begin
                ale_s    = 1'b1;
                gnt0_s   = !owner_next_s;
                gnt1_s   = owner_next_s;
                cs_mem_s = req_next_s.mio;
                cs_io_s  = !req_next_s.mio;
            end
            ST_T2, ST_T3: begin
                cs_mem_s = req_next_s.mio;
                cs_io_s  = !req_next_s.mio;
                if (req_next_s.we) begin
                    wr_n_s    = 1'b0;
                    data_oe_s = 1'b1;
                end else begin
                    rd_n_s    = 1'b0;
                end
            end
            ST_T4: begin
                done0_s = !owner_next_s;
                done1_s = owner_next_s;
            end
            default: begin
                ale_s = 1'b0;
            end
        endcase
    end

    // State, latched request and registered bus outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r   <= ST_IDLE;
            req_r     <= '0;
            owner_r   <= 1'b0;
            rdata_r   <= '0;
            ale_r     <= 1'b0;
            rd_n_r    <= 1'b1;
            wr_n_r    <= 1'b1;
            cs_mem_r  <= 1'b0;
            cs_io_r   <= 1'b0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            data_oe_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            req_r     <= req_next_s;
            owner_r   <= owner_next_s;
            rdata_r   <= rdata_next_s;
            ale_r     <= ale_s;
            rd_n_r    <= rd_n_s;
            wr_n_r    <= wr_n_s;
            cs_mem_r  <= cs_mem_s;
            cs_io_r   <= cs_io_s;
            gnt0_r    <= gnt0_s;
            gnt1_r    <= gnt1_s;
            done0_r   <= done0_s;
            done1_r   <= done1_s;
            data_oe_r <= data_oe_s;
        end
    end

    assign GNT0    = gnt0_r;
    assign GNT1    = gnt1_r;
    assign DONE0   = done0_r;
    assign DONE1   = done1_r;
    assign RDATA   = rdata_r;
    assign ALE     = ale_r;
    assign RD      = rd_n_r;
    assign WR      = wr_n_r;
    assign CS_MEM  = cs_mem_r;
    assign CS_IO   = cs_io_r;
    assign ADDRESS = req_r.addr;
    assign DATA    = data_oe_r ? req_r.wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Directed bench for bus_cycle_arbiter with a small memory/I-O target model.
// Expected grant order follows ARB_ROUND_ROBIN_EN.
module tb_bus_cycle_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, REQ1, WE0, WE1, MIO0, MIO1;
    logic [18:0] ADDR0, ADDR1;
    logic [7:0]  WDATA0, WDATA1;
    logic        GNT0, GNT1, DONE0, DONE1, ALE, RD, WR, CS_MEM, CS_IO;
    logic [7:0]  RDATA;
    logic [18:0] ADDRESS;
    wire  [7:0]  DATA;

    logic [7:0]  mem [32];
    logic [7:0]  io  [32];
    logic        probe;
    logic [7:0]  tgt_data;
    logic        tgt_en;
    int          total = 0;
    int          bad = 0;
    int          order [$];

    always #5 CLK = ~CLK;

    bus_cycle_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .MIO0(MIO0), .MIO1(MIO1), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RDATA(RDATA), .ALE(ALE), .RD(RD), .WR(WR),
        .CS_MEM(CS_MEM), .CS_IO(CS_IO), .ADDRESS(ADDRESS), .DATA(DATA)
    );

    // Target model: drives read data while RD is low; probe drives 00 to expose any other driver
    assign tgt_en   = !RD && (CS_MEM || CS_IO);
    assign tgt_data = CS_MEM ? mem[ADDRESS[4:0]] : io[ADDRESS[4:0]];
    assign DATA     = probe ? 8'h00 : (tgt_en ? tgt_data : 8'hzz);

    always @(posedge CLK) begin
        if (!WR && CS_MEM) mem[ADDRESS[4:0]] <= DATA;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe_free(input string tag);
        probe = 1'b1;
        #1;
        chk(tag, {24'd0, DATA}, 32'h00);
        probe = 1'b0;
        #1;
    endtask

    initial begin
        probe = 1'b0;
        for (int i = 0; i < 32; i++) io[i] = 8'h00;
        io[3] = 8'h5A;
        RESET = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0; MIO0 = 1'b0; MIO1 = 1'b0;
        ADDR0 = 19'd0; ADDR1 = 19'd0; WDATA0 = 8'h00; WDATA1 = 8'h00;
        tick(); tick();
        chk("rst_ale", {31'd0, ALE}, 32'd0);
        chk("rst_rd_wr", {30'd0, RD, WR}, 32'd3);
        chk("rst_cs", {30'd0, CS_MEM, CS_IO}, 32'd0);
        chk("rst_gnt_done", {28'd0, GNT0, GNT1, DONE0, DONE1}, 32'd0);
        chk("rst_addr", {13'd0, ADDRESS}, 32'd0);
        chk("rst_rdata", {24'd0, RDATA}, 32'd0);
        probe_free("rst_data_z");

        // Memory write from requester 0
        RESET = 1'b1;
        REQ0 = 1'b1; WE0 = 1'b1; MIO0 = 1'b1; ADDR0 = 19'h00010; WDATA0 = 8'hA5;
        tick();
        chk("wr_t1_gnt", {30'd0, GNT0, GNT1}, 32'd2);
        chk("wr_t1_ale", {31'd0, ALE}, 32'd1);
        chk("wr_t1_cs", {30'd0, CS_MEM, CS_IO}, 32'd2);
        chk("wr_t1_addr", {13'd0, ADDRESS}, 32'h10);
        chk("wr_t1_strobes", {30'd0, RD, WR}, 32'd3);
        REQ0 = 1'b0; ADDR0 = 19'h7FFFF; WDATA0 = 8'h00;
        tick();
        chk("wr_t2_strobes", {30'd0, RD, WR}, 32'd2);
        chk("wr_t2_ale_gnt", {30'd0, ALE, GNT0}, 32'd0);
        chk("wr_t2_data", {24'd0, DATA}, 32'hA5);
        chk("wr_t2_addr", {13'd0, ADDRESS}, 32'h10);
        tick();
        chk("wr_t3_wr", {31'd0, WR}, 32'd0);
        chk("wr_t3_data", {24'd0, DATA}, 32'hA5);
        tick();
        chk("wr_t4_done", {30'd0, DONE0, DONE1}, 32'd2);
        chk("wr_t4_strobes", {30'd0, RD, WR}, 32'd3);
        chk("wr_t4_cs", {30'd0, CS_MEM, CS_IO}, 32'd0);
        probe_free("wr_t4_data_z");
        tick();
        chk("wr_idle", {29'd0, ALE, DONE0, GNT0}, 32'd0);
        chk("wr_mem", {24'd0, mem[16]}, 32'hA5);

        // Memory read from requester 1 of the location just written
        REQ1 = 1'b1; WE1 = 1'b0; MIO1 = 1'b1; ADDR1 = 19'h00010; WDATA1 = 8'hFF;
        tick();
        chk("rd_t1_gnt", {30'd0, GNT0, GNT1}, 32'd1);
        probe_free("rd_t1_data_z");
        REQ1 = 1'b0;
        tick();
        chk("rd_t2_strobes", {30'd0, RD, WR}, 32'd1);
        tick();
        chk("rd_t3_strobes", {30'd0, RD, WR}, 32'd1);
        tick();
        chk("rd_t4_done", {30'd0, DONE0, DONE1}, 32'd1);
        chk("rd_t4_rdata", {24'd0, RDATA}, 32'hA5);
        chk("rd_t4_rd", {31'd0, RD}, 32'd1);
        probe_free("rd_t4_data_z");
        tick();
        chk("rd_idle_rdata", {24'd0, RDATA}, 32'hA5);

        // Both requesters held for four back-to-back transfers
        REQ0 = 1'b1; WE0 = 1'b0; MIO0 = 1'b1; ADDR0 = 19'h00010;
        REQ1 = 1'b1; WE1 = 1'b0; MIO1 = 1'b1; ADDR1 = 19'h00010;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b2b_gnt_slot", {31'd0, GNT0 | GNT1}, {31'd0, (i % 4) == 0});
            if (GNT0) order.push_back(0);
            if (GNT1) order.push_back(1);
            if (i == 12) begin
                REQ0 = 1'b0;
                REQ1 = 1'b0;
            end
        end
        chk("b2b_count", order.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) begin
`ifdef ARB_ROUND_ROBIN_EN
                chk("b2b_order", order[i], i % 2);
`else
                chk("b2b_order", order[i], 32'd0);
`endif
            end
        end
        tick();
        chk("b2b_idle", {29'd0, ALE, GNT0, GNT1}, 32'd0);

        // I/O read
        REQ0 = 1'b1; WE0 = 1'b0; MIO0 = 1'b0; ADDR0 = 19'h00003;
        tick();
        chk("io_t1_cs", {30'd0, CS_MEM, CS_IO}, 32'd1);
        REQ0 = 1'b0;
        tick();
        chk("io_t2_cs", {30'd0, CS_MEM, CS_IO}, 32'd1);
        tick();
        chk("io_t3_cs", {30'd0, CS_MEM, CS_IO}, 32'd1);
        tick();
        chk("io_t4_cs", {30'd0, CS_MEM, CS_IO}, 32'd0);
        chk("io_t4_rdata", {24'd0, RDATA}, 32'h5A);
        tick();

        // Reset asserted during T3 of a write
        REQ0 = 1'b1; WE0 = 1'b1; MIO0 = 1'b1; ADDR0 = 19'h00005; WDATA0 = 8'h3C;
        tick();
        REQ0 = 1'b0;
        tick();
        tick();
        chk("rst_mid_t3_wr", {31'd0, WR}, 32'd0);
        RESET = 1'b0;
        tick();
        chk("rst_mid_wr", {31'd0, WR}, 32'd1);
        chk("rst_mid_done", {30'd0, DONE0, DONE1}, 32'd0);
        chk("rst_mid_addr", {13'd0, ADDRESS}, 32'd0);
        probe_free("rst_mid_data_z");
        RESET = 1'b1;
        tick();
        chk("rst_mid_idle", {29'd0, ALE, GNT0, DONE0}, 32'd0);
        REQ0 = 1'b1; WDATA0 = 8'hC3;
        tick();
        chk("post_rst_gnt", {31'd0, GNT0}, 32'd1);
        REQ0 = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_done", {31'd0, DONE0}, 32'd1);
        chk("post_rst_mem", {24'd0, mem[5]}, 32'hC3);
        tick();

        // Short REQ0 pulse during a requester-1 transfer is ignored
        REQ1 = 1'b1; WE1 = 1'b0; MIO1 = 1'b0; ADDR1 = 19'h00003;
        tick();
        chk("pulse_t1_gnt1", {30'd0, GNT0, GNT1}, 32'd1);
        REQ1 = 1'b0;
        tick();
        REQ0 = 1'b1;
        tick();
        chk("pulse_t3_gnt0", {31'd0, GNT0}, 32'd0);
        REQ0 = 1'b0;
        tick();
        chk("pulse_t4_done1", {30'd0, DONE0, DONE1}, 32'd1);
        tick();
        chk("pulse_idle", {29'd0, ALE, GNT0, GNT1}, 32'd0);
        tick();
        chk("pulse_idle2", {30'd0, ALE, GNT0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
